// File: rtl/wb_icu.sv
// wb_icu: two-source interrupt control unit with a Wishbone register slave.
//   clk, reset             single clock; asynchronous active-high reset
//   wb_stb_i/cyc_i/we_i    Wishbone strobe, cycle, write enable
//   wb_adr_i[3:0]          word offset (1 EOI, 4 IMASK, 6 INSERV, 7 REQST, 12 I0CON, 13 I1CON)
//   wb_sel_i[1:0]          byte lanes; only lane 0 carries register bits
//   wb_dat_i/wb_dat_o      16-bit write / read data; wb_ack_o one-cycle acknowledge
//   irq_in[1:0]            asynchronous INT0/INT1 requests
//   inta, intr, vector     CPU acknowledge level, request to CPU, acknowledged type
//   nmi_in, nmia, nmi      NMI request, NMI acknowledge, NMI to CPU
// Optional feature: define WB_ICU_NMI_EN to build the NMI path; otherwise nmi is tied low.
module wb_icu #(
  parameter logic [7:0]  VEC_BASE    = 8'h0C,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_adr_i,
  input  logic [1:0]  wb_sel_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  output logic        wb_ack_o,
  input  logic [1:0]  irq_in,
  input  logic        inta,
  output logic        intr,
  output logic [7:0]  vector,
  input  logic        nmi_in,
  input  logic        nmia,
  output logic        nmi
);

  localparam int unsigned DW     = 16;
  localparam int unsigned CW     = 5;
  localparam logic [3:0]  ADR_EOI    = 4'd1;
  localparam logic [3:0]  ADR_IMASK  = 4'd4;
  localparam logic [3:0]  ADR_INSERV = 4'd6;
  localparam logic [3:0]  ADR_REQST  = 4'd7;
  localparam logic [3:0]  ADR_I0CON  = 4'd12;
  localparam logic [3:0]  ADR_I1CON  = 4'd13;
  localparam logic [CW-1:0] CON_RST  = 5'h0F;

  logic [SYNC_STAGES-1:0][1:0] irq_sync_q;
  logic [1:0]          irq_prev_q;
  logic [SYNC_STAGES:0] vld_q;
  logic [1:0]          reqst_q, reqst_d, inserv_q, inserv_d;
  logic [CW-1:0]       con0_q, con0_d, con1_q, con1_d;
  logic                inta_q, intr_q, intr_d, ack_q;
  logic [7:0]          vector_q, vector_d;
  logic [DW-1:0]       dat_q, dat_d, rdata;

  logic [1:0] sync_irq, irq_edge, lvl, mask, reqst_c, pend;
  logic [1:0] eoi_clr, inserv_e, elig, win, ack_vec;
  logic [2:0] pri0, pri1;
  logic       acc, wr, inta_rise;
  logic       unused_bits;

  assign unused_bits = ^{wb_sel_i[1], wb_dat_i[14:8]};

  // vld_q tracks how far real post-reset samples have travelled, so a request
  // already high during reset is not mistaken for a rising edge.
  assign sync_irq  = irq_sync_q[SYNC_STAGES-1];
  assign irq_edge  = sync_irq & ~irq_prev_q & {2{vld_q[SYNC_STAGES]}};
  assign lvl       = {con1_q[4], con0_q[4]};
  assign mask      = {con1_q[3], con0_q[3]};
  assign pri0      = con0_q[2:0];
  assign pri1      = con1_q[2:0];
  // Level-mode requests follow the synchroniser directly.
  assign reqst_c   = (lvl & sync_irq) | (~lvl & reqst_q);
  assign acc       = wb_stb_i & wb_cyc_i & ~ack_q;
  assign wr        = acc & wb_we_i & wb_sel_i[0];
  assign inta_rise = inta & ~inta_q;

  // Register writes, EOI, arbitration and acknowledge.
  always_comb begin
    con0_d   = con0_q;
    con1_d   = con1_q;
    eoi_clr  = 2'b00;
    rdata    = '0;
    vector_d = vector_q;

    if (wr) begin
      case (wb_adr_i)
        ADR_IMASK: begin con0_d[3] = wb_dat_i[0]; con1_d[3] = wb_dat_i[1]; end
        ADR_I0CON: con0_d = wb_dat_i[CW-1:0];
        ADR_I1CON: con1_d = wb_dat_i[CW-1:0];
        ADR_EOI: begin
          if (wb_dat_i[15]) begin
            if (inserv_q[0] && (!inserv_q[1] || pri0 <= pri1)) eoi_clr = 2'b01;
            else if (inserv_q[1])                              eoi_clr = 2'b10;
          end else if (wb_dat_i[7:0] == VEC_BASE) begin
            eoi_clr = 2'b01;
          end else if (wb_dat_i[7:0] == 8'(VEC_BASE + 8'd1)) begin
            eoi_clr = 2'b10;
          end
        end
        default: ;
      endcase
    end

    // Acknowledge sees INSERV after any EOI landing in the same cycle.
    inserv_e = inserv_q & ~eoi_clr;
    pend     = reqst_c & ~mask;
    elig[0]  = pend[0] & ~inserv_e[0] & (~inserv_e[1] | (pri0 < pri1));
    elig[1]  = pend[1] & ~inserv_e[1] & (~inserv_e[0] | (pri1 < pri0));
    win[0]   = elig[0] & (~elig[1] | (pri0 <= pri1));
    win[1]   = elig[1] & ~win[0];
    ack_vec  = inta_rise ? win : 2'b00;

    inserv_d = inserv_e | ack_vec;
    reqst_d  = (lvl & sync_irq) | (~lvl & ~ack_vec & (reqst_q | irq_edge));
    intr_d   = (|elig) & ~inta_rise;

    if (inta_rise) begin
      if (win[0])      vector_d = VEC_BASE;
      else if (win[1]) vector_d = 8'(VEC_BASE + 8'd1);
      else             vector_d = 8'(VEC_BASE + 8'd7);
    end

    case (wb_adr_i)
      ADR_IMASK:  rdata = {14'b0, mask};
      ADR_INSERV: rdata = {14'b0, inserv_q};
      ADR_REQST:  rdata = {14'b0, reqst_c};
      ADR_I0CON:  rdata = {11'b0, con0_q};
      ADR_I1CON:  rdata = {11'b0, con1_q};
      default:    rdata = '0;
    endcase
    dat_d = (acc && !wb_we_i) ? rdata : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_sync_q <= '0;
      irq_prev_q <= '0;
      vld_q      <= '0;
      reqst_q    <= '0;
      inserv_q   <= '0;
      con0_q     <= CON_RST;
      con1_q     <= CON_RST;
      inta_q     <= 1'b0;
      intr_q     <= 1'b0;
      vector_q   <= VEC_BASE;
      ack_q      <= 1'b0;
      dat_q      <= '0;
    end else begin
      irq_sync_q <= {irq_sync_q[SYNC_STAGES-2:0], irq_in};
      irq_prev_q <= sync_irq;
      vld_q      <= {vld_q[SYNC_STAGES-1:0], 1'b1};
      reqst_q    <= reqst_d;
      inserv_q   <= inserv_d;
      con0_q     <= con0_d;
      con1_q     <= con1_d;
      inta_q     <= inta;
      intr_q     <= intr_d;
      vector_q   <= vector_d;
      ack_q      <= acc;
      dat_q      <= dat_d;
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign intr     = intr_q;
  assign vector   = vector_q;

`ifdef WB_ICU_NMI_EN
  logic [SYNC_STAGES-1:0] nmi_sync_q;
  logic                   nmi_prev_q, nmi_q, nmi_d, nmi_edge;

  assign nmi_edge = nmi_sync_q[SYNC_STAGES-1] & ~nmi_prev_q & vld_q[SYNC_STAGES];

  // Acknowledge wins over a coincident new edge.
  always_comb begin
    nmi_d = nmi_q;
    if (nmia)          nmi_d = 1'b0;
    else if (nmi_edge) nmi_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nmi_sync_q <= '0;
      nmi_prev_q <= 1'b0;
      nmi_q      <= 1'b0;
    end else begin
      nmi_sync_q <= {nmi_sync_q[SYNC_STAGES-2:0], nmi_in};
      nmi_prev_q <= nmi_sync_q[SYNC_STAGES-1];
      nmi_q      <= nmi_d;
    end
  end

  assign nmi = nmi_q;
`else
  logic unused_nmi;
  assign unused_nmi = nmi_in ^ nmia;
  assign nmi        = 1'b0;
`endif

endmodule
